// File: rtl/load_pkg.sv
// load_pkg: shared opcode/funct3 constants and FSM state type for the load data unit.
package load_pkg;
    localparam logic [4:0] LOAD_OPCODE = 5'b00000;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} ld_state_t;
endpackage

// File: rtl/load_extend.sv
// load_extend: selects the addressed byte/halfword of a read word and sign/zero-extends it.
module load_extend
    import load_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b = 8'(word >> {offset, 3'b000});
        h = offset[1] ? word[31:16] : word[15:0];
        result = funct3 == F3_LB  ? {{24{b[7]}}, b} :
                 funct3 == F3_LBU ? {24'b0, b} :
                 funct3 == F3_LH  ? {{16{h[15]}}, h} :
                 funct3 == F3_LHU ? {16'b0, h} :
                 funct3 == F3_LW  ? word : 32'b0;
    end
endmodule

// File: rtl/load_data_unit.sv
// load_data_unit: MEM-stage load FSM doing a word read handshake and formatting the writeback value.
// Define LOAD_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW instead of reading memory.
module load_data_unit
    import load_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] addr,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_rvalid,
    output logic [XLEN-1:0] load_data,
    output logic            load_done,
    output logic            stall,
    output logic            bus_err,
    output logic            misalign_exc
);
    ld_state_t   state;
    logic [7:0]  cnt;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic [31:0] ext;
    logic        accept;
    logic        mis;

    load_extend u_ext (.word(mem_rdata), .offset(off), .funct3(f3), .result(ext));

    assign accept    = state == IDLE && issue_valid && opcode == LOAD_OPCODE;
    assign stall     = accept || state == REQ || state == WAIT;
    assign mem_req   = state == REQ;
    assign load_done = state == DONE;
`ifdef LOAD_MISALIGN_TRAP_EN
    assign mis = ((funct3 == F3_LH || funct3 == F3_LHU) && addr[0]) || (funct3 == F3_LW && addr[1:0] != 2'b00);
`else
    assign mis = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            off          <= '0;
            f3           <= '0;
            mem_addr     <= '0;
            load_data    <= '0;
            bus_err      <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    off          <= addr[1:0];
                    f3           <= funct3;
                    mem_addr     <= {addr[XLEN-1:2], 2'b00};
                    bus_err      <= 1'b0;
                    misalign_exc <= mis;
                    if (mis) load_data <= '0;
                    state        <= mis ? DONE : REQ;
                end
                REQ: if (mem_gnt) begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    // rvalid takes priority over a simultaneous timeout
                    if (mem_rvalid) begin
                        load_data <= ext;
                        state     <= DONE;
                    end else if (cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        load_data <= '0;
                        bus_err   <= 1'b1;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_data_unit.sv
// tb_load_data_unit: table-driven load vectors checked through a scoreboard, plus reset and non-load sequences.
module tb_load_data_unit;
    logic        clk = 0;
    logic        rst = 1;
    logic        issue_valid = 0;
    logic [4:0]  opcode = 0;
    logic [2:0]  funct3 = 0;
    logic [31:0] addr = 0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 0;
    logic [31:0] mem_rdata = 0;
    logic        mem_rvalid = 0;
    logic [31:0] load_data;
    logic        load_done;
    logic        stall;
    logic        bus_err;
    logic        misalign_exc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        int          gd;
        int          rd;
        logic [31:0] data;
        bit          mis;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[13];

    load_data_unit #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .opcode(opcode), .funct3(funct3),
        .addr(addr), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .load_data(load_data),
        .load_done(load_done), .stall(stall), .bus_err(bus_err), .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input vec_t v);
        exp_t e, got;
        int dc, nr, nreq, stall_bad, addr_bad, kd;
        e.data = v.data;
        e.err  = v.rd < 0;
        e.mis  = 0;
        dc = v.rd < 0 ? 18 + v.gd : 3 + v.gd + v.rd;
        nr = v.gd + 1;
`ifdef LOAD_MISALIGN_TRAP_EN
        if (v.mis) begin
            e.data = 0; e.err = 0; e.mis = 1; dc = 1; nr = 0;
        end
`endif
        sb.push_back(e);
        nreq = 0; stall_bad = 0; addr_bad = 0; kd = 0;
        @(posedge clk); #1;
        issue_valid = 1; opcode = 5'b00000; funct3 = v.f3; addr = v.addr; mem_rdata = v.rdata;
        @(negedge clk);
        chk("stall_accept", stall, 1);
        for (int k = 1; k <= 40 && kd == 0; k++) begin
            @(posedge clk); #1;
            issue_valid = 0;
            mem_gnt    = (k == 1 + v.gd);
            mem_rvalid = (v.rd >= 0) && (k == 2 + v.gd + v.rd);
            @(negedge clk);
            if (mem_req) begin
                nreq++;
                if (mem_addr !== {v.addr[31:2], 2'b00}) addr_bad++;
            end
            if (load_done) begin
                kd = k;
                if (sb.size() == 0) begin
                    chk("sb_empty", 1, 0);
                end else begin
                    got = sb.pop_front();
                    chk("load_data", load_data, got.data);
                    chk("bus_err", bus_err, got.err);
                    chk("misalign_exc", misalign_exc, got.mis);
                end
                chk("stall_done", stall, 0);
            end else if (!stall) begin
                stall_bad++;
            end
        end
        @(posedge clk); #1;
        mem_gnt = 0; mem_rvalid = 0;
        if (kd == 0) begin
            chk("done_timeout", 0, 1);
            void'(sb.pop_front());
        end
        chk("done_cycle", kd, dc);
        chk("req_cycles", nreq, nr);
        chk("req_addr_bad", addr_bad, 0);
        chk("stall_gap", stall_bad, 0);
        @(negedge clk);
        chk("done_strobe", load_done, 0);
        chk("data_hold", load_data, e.data);
    endtask

    initial begin
        vecs[0]  = '{3'b000, 32'h103, 32'h80AABBCC, 0, 0, 32'hFFFFFF80, 0};
        vecs[1]  = '{3'b100, 32'h103, 32'h80AABBCC, 0, 0, 32'h00000080, 0};
        vecs[2]  = '{3'b101, 32'h102, 32'h9ABC1234, 0, 0, 32'h00009ABC, 0};
        vecs[3]  = '{3'b001, 32'h102, 32'h9ABC1234, 0, 0, 32'hFFFF9ABC, 0};
        vecs[4]  = '{3'b010, 32'h200, 32'h13579BDF, 3, 2, 32'h13579BDF, 0};
        vecs[5]  = '{3'b010, 32'h300, 32'h55555555, 0, -1, 32'h00000000, 0};
        vecs[6]  = '{3'b010, 32'h304, 32'hCAFEF00D, 0, 15, 32'hCAFEF00D, 0};
        vecs[7]  = '{3'b010, 32'h101, 32'h11223344, 0, 0, 32'h11223344, 1};
        vecs[8]  = '{3'b000, 32'h100, 32'h1234567F, 1, 1, 32'h0000007F, 0};
        vecs[9]  = '{3'b001, 32'h100, 32'hFFFF8001, 0, 0, 32'hFFFF8001, 0};
        vecs[10] = '{3'b011, 32'h400, 32'hFFFFFFFF, 0, 0, 32'h00000000, 0};
        vecs[11] = '{3'b001, 32'h103, 32'h80001234, 0, 0, 32'hFFFF8000, 1};
        vecs[12] = '{3'b100, 32'h101, 32'hA1B2C3D4, 2, 0, 32'h000000C3, 0};

        #2;
        chk("rst_load_data", load_data, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_misalign", misalign_exc, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 13; i++) do_load(vecs[i]);

        // non-load instruction must be ignored
        @(posedge clk); #1;
        issue_valid = 1; opcode = 5'b01000; funct3 = 3'b010; addr = 32'h600;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nonload_stall", stall, 0);
            chk("nonload_req", mem_req, 0);
            chk("nonload_done", load_done, 0);
        end
        @(posedge clk); #1;
        issue_valid = 0;

        // reset while waiting for read data, then a stale rvalid
        @(posedge clk); #1;
        issue_valid = 1; opcode = 5'b00000; funct3 = 3'b010; addr = 32'h500; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        issue_valid = 0; mem_gnt = 1;
        @(posedge clk); #1;
        mem_gnt = 0;
        @(posedge clk); #2;
        rst = 1;
        #1;
        chk("midrst_stall", stall, 0);
        chk("midrst_load_data", load_data, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_bus_err", bus_err, 0);
        chk("midrst_done", load_done, 0);
        @(negedge clk);
        rst = 0;
        @(posedge clk); #1;
        mem_rvalid = 1;
        @(posedge clk); #1;
        mem_rvalid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stale_done", load_done, 0);
            chk("stale_req", mem_req, 0);
            chk("stale_stall", stall, 0);
        end
        chk("stale_data", load_data, 0);
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/load_data_unit.md
Name: load_data_unit

Overview:
- Load-side companion to the store-data formatter in the MEM stage.
- Accepts a load issued by the pipeline and stalls the pipeline while it runs.
- Performs a word-aligned read handshake with data memory.
- Extracts the addressed byte or halfword, sign- or zero-extends it per funct3, and returns the 32-bit writeback value with a one-cycle done strobe.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles spent in WAIT before a bus error completes the load (range 1..255).
- XLEN, 32: data/address width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- issue_valid  in  1  MEM-stage instruction valid.
- opcode  in  5  instruction bits [6:2]; a load is 5'b00000.
- funct3  in  3  load width/sign select.
- addr  in  32  effective byte address.
- mem_req  out  1  read request to data memory.
- mem_addr  out  32  word address, {addr[31:2],2'b00}.
- mem_gnt  in  1  memory accepted the request.
- mem_rdata  in  32  read word.
- mem_rvalid  in  1  mem_rdata valid.
- load_data  out  32  formatted writeback value.
- load_done  out  1  one-cycle completion strobe.
- stall  out  1  hold the upstream pipeline.
- bus_err  out  1  timeout flag, valid with load_done.
- misalign_exc  out  1  misaligned-access flag, valid with load_done.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0; mem_req, mem_addr, load_data, load_done, bus_err and misalign_exc all 0.
- A load is accepted in IDLE when issue_valid && opcode==5'b00000.
- Funct3 decode: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; 011, 110 and 111 are reserved.
- stall is combinational: 1 when a load is accepted in IDLE, and 1 throughout REQ and WAIT; 0 in DONE.
- FSM states: IDLE, REQ, WAIT, DONE.
  - IDLE: on accept, latch addr[1:0], funct3 and the word address; go to REQ. Non-loads are ignored. A mem_rvalid seen in IDLE is ignored.
  - REQ: drive mem_req=1 and mem_addr. On mem_gnt, go to WAIT and clear the counter; otherwise stay in REQ.
  - WAIT: mem_req=0 and the counter increments.
    - On mem_rvalid: latch the formatted data into load_data and go to DONE.
    - When the counter reaches TIMEOUT_CYCLES-1 without rvalid: load_data=0, bus_err=1, go to DONE.
    - If rvalid arrives in the same cycle as the timeout, rvalid wins.
  - DONE: load_done=1 for exactly one cycle, then go to IDLE. A new load is accepted no earlier than the cycle after DONE.
- Minimum latency: accept at cycle 0; REQ with gnt at cycle 1; rvalid at cycle 2; load_done at cycle 3.
- Formatting, with b = addr[1:0]:
  - Byte: mem_rdata[8*b +: 8].
  - Halfword: mem_rdata[31:16] if addr[1], else mem_rdata[15:0].
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passes the word through.
  - Reserved funct3 yields 0 but still completes normally.
- Output holding:
  - load_data holds its value until the next completion.
  - bus_err and misalign_exc are cleared at the next accept.
- issue_valid while busy is ignored; the pipeline is stalled, so the instruction is held upstream.
- Reset mid-operation drops mem_req immediately. Any response that arrives afterwards is discarded.

Optional Feature:
- Macro: LOAD_MISALIGN_TRAP_EN.
- Defined:
  - Misalignment is LH/LHU with addr[0]=1, or LW with addr[1:0]!=0.
  - A misaligned load skips REQ and WAIT and goes IDLE->DONE with misalign_exc=1 and load_data=0.
  - No mem_req is issued.
- Undefined:
  - misalign_exc is tied to 0.
  - LH/LHU ignore addr[0]; LW ignores addr[1:0].

Decomposition:
- Package load_pkg holds:
  - LOAD_OPCODE = 5'b00000.
  - Funct3 constants F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU.
  - Typedef ld_state_t enum {IDLE, REQ, WAIT, DONE}.
- Sub-module load_extend: combinational (word, offset, funct3) -> 32-bit result. The FSM instantiates it once.

Test Plan:
- LB, addr=0x103, mem_rdata=0x80AABBCC, gnt and rvalid immediate -> load_data=0xFFFFFF80, load_done at cycle 3, stall high for cycles 0-2.
- LBU, same stimulus -> load_data=0x00000080. LHU, addr=0x102, rdata=0x9ABC1234 -> 0x00009ABC. LH, same stimulus -> 0xFFFF9ABC.
- LW, addr=0x200; mem_gnt held low 3 cycles; rvalid 2 cycles after gnt -> mem_req high 4 cycles, mem_addr=0x200, load_data=rdata, stall deasserts in the DONE cycle.
- No rvalid for TIMEOUT_CYCLES=16 -> bus_err=1, load_data=0, load_done after 16 WAIT cycles. Rvalid on the final WAIT cycle instead -> data returned, bus_err=0.
- With LOAD_MISALIGN_TRAP_EN, LW addr=0x101 -> no mem_req, misalign_exc=1 and load_done on cycle 1. Without the macro -> normal read, word returned.
- Assert rst during WAIT, then pulse rvalid after release -> state IDLE, all outputs 0, load_done never asserts. Non-load opcode 5'b01000 with issue_valid -> stall=0, no request.
